// File: rtl/rv32i_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path: opcode
// constants, the datapath control encodings (kept identical to the
// single-cycle core so the datapath muxes need no change), the instruction
// class enumeration and the control-FSM state enumeration.
// ---------------------------------------------------------------------------
package rv32i_ctrl_pkg;

  // Major opcodes, instruction[6:0]
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU operation class (funct-level decode happens in the ALU decoder)
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Next-PC source
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;

  // Register-file write-back source
  localparam logic [1:0] MTR_ALU   = 2'b00;
  localparam logic [1:0] MTR_MEM   = 2'b01;
  localparam logic [1:0] MTR_IMM   = 2'b10;
  localparam logic [1:0] MTR_PC4   = 2'b11;

  // Immediate format
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;

  // Width of the memory wait counter (covers MEM_WAIT_MAX up to 255)
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ERR,
    TRAP
  } mc_state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } op_class_e;

  // Controls that depend only on the instruction class, not on the state
  typedef struct packed {
    logic       a_sel;     // 0 = rs1, 1 = PC
    logic       b_sel;     // 0 = rs2, 1 = immediate
    logic [1:0] alu_op;
    logic [2:0] immsrc;
    logic [1:0] memtoreg;
    logic [1:0] pc_src;    // PC source used by the write-back PC update
  } static_ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// ---------------------------------------------------------------------------
// mc_decode
// Purely combinational opcode classifier. Maps the IR opcode to an
// instruction class plus the class-static datapath controls; the FSM
// decides when those controls are actually driven.
// Ports:
//   opcode_i  in   7   instruction[6:0]
//   cls_o     out      instruction class (CLS_ILLEGAL when unrecognised)
//   ctrl_o    out      static controls for that class
// ---------------------------------------------------------------------------
module mc_decode
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output op_class_e    cls_o,
  output static_ctrl_t ctrl_o
);

  always_comb begin
    // NOTE: every signal written here gets a default first, so an
    // unmatched opcode can never leave a latch behind.
    cls_o  = CLS_ILLEGAL;
    ctrl_o = '0;
    unique case (opcode_i)
      OP_R: begin
        cls_o         = CLS_R;
        ctrl_o.alu_op = ALU_FUNCT;
      end
      OP_I: begin
        cls_o         = CLS_I;
        ctrl_o.b_sel  = 1'b1;
        ctrl_o.alu_op = ALU_FUNCT;
        ctrl_o.immsrc = IMM_I;
      end
      OP_LOAD: begin
        cls_o           = CLS_LOAD;
        ctrl_o.b_sel    = 1'b1;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.immsrc   = IMM_I;
        ctrl_o.memtoreg = MTR_MEM;
      end
      OP_STORE: begin
        cls_o         = CLS_STORE;
        ctrl_o.b_sel  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;
        ctrl_o.immsrc = IMM_S;
      end
      OP_BRANCH: begin
        // ALU compares rs1/rs2; the target adder uses the B immediate
        cls_o         = CLS_BRANCH;
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.immsrc = IMM_B;
      end
      OP_LUI: begin
        cls_o           = CLS_LUI;
        ctrl_o.b_sel    = 1'b1;
        ctrl_o.immsrc   = IMM_U;
        ctrl_o.memtoreg = MTR_IMM;
      end
      OP_AUIPC: begin
        cls_o         = CLS_AUIPC;
        ctrl_o.a_sel  = 1'b1;
        ctrl_o.b_sel  = 1'b1;
        ctrl_o.immsrc = IMM_U;
      end
      OP_JAL: begin
        cls_o           = CLS_JAL;
        ctrl_o.a_sel    = 1'b1;
        ctrl_o.b_sel    = 1'b1;
        ctrl_o.immsrc   = IMM_J;
        ctrl_o.memtoreg = MTR_PC4;
        ctrl_o.pc_src   = PC_TARGET;
      end
      OP_JALR: begin
        cls_o           = CLS_JALR;
        ctrl_o.b_sel    = 1'b1;
        ctrl_o.immsrc   = IMM_I;
        ctrl_o.memtoreg = MTR_PC4;
        ctrl_o.pc_src   = PC_ALU;
      end
      default: begin
        cls_o  = CLS_ILLEGAL;
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Control FSM of the multi-cycle RV32I core with a unified memory port.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with a per-request
// wait counter that sends the FSM to the sticky ERR state on timeout.
//
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN to send unrecognised opcodes
// to the sticky TRAP state (illegal_o = 1); otherwise they retire as NOPs
// and illegal_o is tied low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode_i          instruction[6:0] from the IR
//   branch_taken_i    branch comparison result (sampled in EXEC)
//   mem_ack_i         one-cycle memory completion pulse
//   mem_req_o, mem_we_o, iord_o          memory request / write / address sel
//   ir_we_o, mdr_we_o, pc_we_o, reg_we_o architectural write enables
//   a_sel_o, b_sel_o, alu_op_o, immsrc_o ALU operand / op / immediate controls
//   pc_src_o, memtoreg_o                 next-PC and write-back source
//   instret_o         pulse per retired instruction
//   mem_err_o         sticky memory timeout flag
//   illegal_o         sticky illegal-instruction flag (trap build only)
// ---------------------------------------------------------------------------
module mc_control_fsm
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_we_o,
  output logic       mdr_we_o,
  output logic       pc_we_o,
  output logic       reg_we_o,
  output logic       a_sel_o,
  output logic       b_sel_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] memtoreg_o,
  output logic [2:0] immsrc_o,
  output logic       instret_o,
  output logic       mem_err_o,
  output logic       illegal_o
);

  // Counter value of the last permitted unacknowledged request cycle
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

  mc_state_e               state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  op_class_e               op_cls;
  static_ctrl_t            ctrl;
  logic                    drive_alu;

  mc_decode u_decode (
    .opcode_i (opcode_i),
    .cls_o    (op_cls),
    .ctrl_o   (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;        // cleared whenever not counting, i.e. on entry to FETCH/MEM
    drive_alu  = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    iord_o     = 1'b0;
    ir_we_o    = 1'b0;
    mdr_we_o   = 1'b0;
    pc_we_o    = 1'b0;
    reg_we_o   = 1'b0;
    a_sel_o    = 1'b0;
    b_sel_o    = 1'b0;
    alu_op_o   = '0;
    pc_src_o   = '0;
    memtoreg_o = '0;
    immsrc_o   = '0;
    instret_o  = 1'b0;

    // NOTE: outputs are gated by rst_n itself so they drop to 0 the moment
    // reset asserts, not at the next clock edge (FETCH would otherwise keep
    // mem_req_o high throughout reset).
    if (rst_n) begin
      unique case (state_q)
        FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            ir_we_o = 1'b1;
            state_d = DECODE;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DECODE: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = (op_cls == CLS_ILLEGAL) ? TRAP : EXEC;
`else
          state_d = EXEC;
`endif
        end

        EXEC: begin
          drive_alu = 1'b1;
          unique case (op_cls)
            CLS_BRANCH: begin
              pc_we_o   = 1'b1;
              pc_src_o  = branch_taken_i ? PC_TARGET : PC_PLUS4;
              instret_o = 1'b1;
              state_d   = FETCH;
            end
            CLS_ILLEGAL: begin
              // Unrecognised opcode retires as a NOP
              pc_we_o   = 1'b1;
              pc_src_o  = PC_PLUS4;
              instret_o = 1'b1;
              state_d   = FETCH;
            end
            CLS_LOAD, CLS_STORE: state_d = MEM;
            default:             state_d = WB;
          endcase
        end

        MEM: begin
          // ALU result is the address, so its controls stay driven
          drive_alu = 1'b1;
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
          mem_we_o  = (op_cls == CLS_STORE);
          if (mem_ack_i) begin
            if (op_cls == CLS_STORE) begin
              pc_we_o   = 1'b1;
              pc_src_o  = PC_PLUS4;
              instret_o = 1'b1;
              state_d   = FETCH;
            end else begin
              mdr_we_o = 1'b1;
              state_d  = WB;
            end
          end else if (cnt_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        WB: begin
          // No ALU output register, so ALU/JALR results are still combinational
          drive_alu  = 1'b1;
          reg_we_o   = 1'b1;
          memtoreg_o = ctrl.memtoreg;
          pc_we_o    = 1'b1;
          pc_src_o   = ctrl.pc_src;
          instret_o  = 1'b1;
          state_d    = FETCH;
        end

        ERR, TRAP: state_d = state_q;   // sticky until reset

        default: state_d = ERR;
      endcase

      if (drive_alu) begin
        a_sel_o  = ctrl.a_sel;
        b_sel_o  = ctrl.b_sel;
        alu_op_o = ctrl.alu_op;
        immsrc_o = ctrl.immsrc;
      end
    end
  end

  assign mem_err_o = rst_n && (state_q == ERR);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = rst_n && (state_q == TRAP);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
// Self-checking bench for mc_control_fsm. Each instruction is run with
// chosen memory latencies; the observed events (cycle count, write-enable
// counts, mux selects) are compared with values derived from the
// instruction class rules (CPI table, write-back source, PC source).
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode_i;
  logic       branch_taken_i;
  logic       mem_ack_i;
  logic       mem_req_o, mem_we_o, iord_o;
  logic       ir_we_o, mdr_we_o, pc_we_o, reg_we_o;
  logic       a_sel_o, b_sel_o;
  logic [1:0] alu_op_o, pc_src_o, memtoreg_o;
  logic [2:0] immsrc_o;
  logic       instret_o, mem_err_o, illegal_o;

  int checks = 0;
  int errors = 0;

  mc_control_fsm #(.MEM_WAIT_MAX(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .mem_ack_i      (mem_ack_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .iord_o         (iord_o),
    .ir_we_o        (ir_we_o),
    .mdr_we_o       (mdr_we_o),
    .pc_we_o        (pc_we_o),
    .reg_we_o       (reg_we_o),
    .a_sel_o        (a_sel_o),
    .b_sel_o        (b_sel_o),
    .alu_op_o       (alu_op_o),
    .pc_src_o       (pc_src_o),
    .memtoreg_o     (memtoreg_o),
    .immsrc_o       (immsrc_o),
    .instret_o      (instret_o),
    .mem_err_o      (mem_err_o),
    .illegal_o      (illegal_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_LUI, K_AUIPC,
                    K_JAL, K_JALR, K_NOP} kind_e;

  function automatic kind_e kind_of(input logic [6:0] op);
    case (op)
      7'h33:   return K_R;
      7'h13:   return K_I;
      7'h03:   return K_LOAD;
      7'h23:   return K_STORE;
      7'h63:   return K_BRANCH;
      7'h37:   return K_LUI;
      7'h17:   return K_AUIPC;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      default: return K_NOP;
    endcase
  endfunction

  // {a_sel, b_sel, alu_op[1:0], immsrc[2:0]} driven in EXEC
  function automatic logic [6:0] exp_exec_ctl(input kind_e k);
    case (k)
      K_R:      return 7'b0_0_10_000;
      K_I:      return 7'b0_1_10_000;
      K_LOAD:   return 7'b0_1_00_000;
      K_STORE:  return 7'b0_1_00_001;
      K_BRANCH: return 7'b0_0_01_010;
      K_LUI:    return 7'b0_1_00_100;
      K_AUIPC:  return 7'b1_1_00_100;
      K_JAL:    return 7'b1_1_00_011;
      K_JALR:   return 7'b0_1_00_000;
      default:  return 7'b0_0_00_000;
    endcase
  endfunction

  function automatic logic [6:0] cur_ctl();
    return {a_sel_o, b_sel_o, alu_op_o, immsrc_o};
  endfunction

  function automatic logic [21:0] all_outputs();
    return {mem_req_o, mem_we_o, iord_o, ir_we_o, mdr_we_o, pc_we_o, reg_we_o,
            a_sel_o, b_sel_o, alu_op_o, pc_src_o, memtoreg_o, immsrc_o,
            instret_o, mem_err_o, illegal_o};
  endfunction

  // Runs one instruction from its first FETCH cycle until instret_o.
  // fw / mw: extra cycles before the fetch / data ack. Called at a negedge.
  task automatic run_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
    kind_e      k = kind_of(op);
    bit         is_mem = (k == K_LOAD) || (k == K_STORE);
    bit         has_reg = !(is_mem && k == K_STORE) && (k != K_BRANCH) && (k != K_NOP);
    int         exp_cycles;
    logic [1:0] exp_m2r, exp_pcsrc;
    int c = 0, req_run = 0, req_idx = 0;
    int n_req = 0, n_iord = 0, n_memwe = 0, n_ir = 0, n_ir_ack = 0;
    int n_reg = 0, n_pc = 0, n_mdr = 0, n_err = 0, n_unstable = 0;
    logic [1:0] m2r_seen = '0, pcsrc_seen = '0;
    logic [6:0] exec_ctl = '0, mem_ctl = '0;
    bit mem_ctl_valid = 0, done = 0;
    string t = k.name();

    exp_cycles = ((k == K_BRANCH || k == K_NOP) ? 3 : (k == K_LOAD) ? 5 : 4)
                 + fw + (is_mem ? mw : 0);
    case (k)
      K_LOAD:       exp_m2r = 2'b01;
      K_LUI:        exp_m2r = 2'b10;
      K_JAL, K_JALR: exp_m2r = 2'b11;
      default:      exp_m2r = 2'b00;
    endcase
    case (k)
      K_JAL:    exp_pcsrc = 2'b01;
      K_JALR:   exp_pcsrc = 2'b10;
      K_BRANCH: exp_pcsrc = taken ? 2'b01 : 2'b00;
      default:  exp_pcsrc = 2'b00;
    endcase

    while (!done && c < 64) begin
      c++;
      branch_taken_i = taken;
      if (mem_req_o) mem_ack_i = (req_run == ((req_idx == 0) ? fw : mw));
      else           mem_ack_i = 1'($urandom_range(0, 1));   // stray acks must be ignored
      #1;
      if (mem_req_o) begin n_req++; req_run++; end
      if (mem_req_o && iord_o) begin
        n_iord++;
        if (!mem_ctl_valid) begin mem_ctl = cur_ctl(); mem_ctl_valid = 1; end
        else if (cur_ctl() != mem_ctl) n_unstable++;
      end
      if (mem_we_o) n_memwe++;
      if (ir_we_o) begin
        n_ir++;
        if (mem_ack_i) n_ir_ack++;
        opcode_i = op;          // IR now holds the new instruction
      end
      if (reg_we_o) begin n_reg++; m2r_seen = memtoreg_o; end
      if (pc_we_o)  begin n_pc++;  pcsrc_seen = pc_src_o; end
      if (mdr_we_o) n_mdr++;
      if (mem_err_o) n_err++;
      if (c == fw + 3) exec_ctl = cur_ctl();
      if (mem_req_o && mem_ack_i) begin req_idx++; req_run = 0; end
      if (instret_o) done = 1;
      @(negedge clk);
    end
    mem_ack_i = 1'b0;

    check({t, "_retired"},  32'(done), 32'd1);
    check({t, "_cycles"},   c, exp_cycles);
    check({t, "_ir_we"},    n_ir, 1);
    check({t, "_ir_on_ack"}, n_ir_ack, 1);
    check({t, "_req_cyc"},  n_req, fw + 1 + (is_mem ? mw + 1 : 0));
    check({t, "_iord_cyc"}, n_iord, is_mem ? mw + 1 : 0);
    check({t, "_memwe_cyc"}, n_memwe, (k == K_STORE) ? mw + 1 : 0);
    check({t, "_reg_we"},   n_reg, has_reg ? 1 : 0);
    check({t, "_memtoreg"}, 32'(m2r_seen), has_reg ? 32'(exp_m2r) : 32'd0);
    check({t, "_pc_we"},    n_pc, 1);
    check({t, "_pc_src"},   32'(pcsrc_seen), 32'(exp_pcsrc));
    check({t, "_mdr_we"},   n_mdr, (k == K_LOAD) ? 1 : 0);
    check({t, "_exec_ctl"}, 32'(exec_ctl), 32'(exp_exec_ctl(k)));
    check({t, "_mem_ctl_stable"}, n_unstable, 0);
    check({t, "_no_err"},   n_err, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                           7'h6F, 7'h67, 7'h7F};

  initial begin
    int reqc;
    int n_ops;
    rst_n          = 1'b0;
    opcode_i       = 7'h00;
    branch_taken_i = 1'b0;
    mem_ack_i      = 1'b0;

    // Reset: every output low while rst_n is asserted
    #12;
    check("reset_outputs_zero", 32'(all_outputs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_fetch_req", 32'(mem_req_o), 32'd1);
    check("first_fetch_iord", 32'(iord_o), 32'd0);

    // Directed: ADDI with one-cycle acks, LW with 3-cycle data wait, BEQ both ways
    run_instr(7'h13, 1'b0, 1, 1);
    run_instr(7'h03, 1'b0, 0, 3);
    run_instr(7'h63, 1'b1, 0, 0);
    run_instr(7'h63, 1'b0, 2, 0);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    run_instr(7'h7F, 1'b1, 0, 0);
`endif

    // Randomized instruction stream
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    n_ops = 9;
`else
    n_ops = 10;
`endif
    for (int i = 0; i < 80; i++) begin
      run_instr(ops[$urandom_range(0, n_ops - 1)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a store's MEM phase
    mem_ack_i = 1'b1;
    #1 opcode_i = 7'h23;
    @(negedge clk);                 // DECODE
    mem_ack_i = 1'b0;
    @(negedge clk);                 // EXEC
    @(negedge clk);                 // MEM
    #1;
    check("sw_mem_req", 32'({mem_req_o, mem_we_o, iord_o}), 32'b111);
    #2 rst_n = 1'b0;
    #1;
    check("sw_async_drop", 32'({mem_req_o, mem_we_o, instret_o}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1 check("sw_in_reset", 32'(all_outputs()), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sw_restart_fetch", 32'({mem_req_o, iord_o, mem_we_o}), 32'b100);
    run_instr(7'h33, 1'b0, 0, 0);

    // Fetch timeout: 15 unacknowledged request cycles then sticky ERR
    reqc = 0;
    for (int i = 0; i < 15; i++) begin
      mem_ack_i = 1'b0;
      #1 if (mem_req_o) reqc++;
      @(negedge clk);
    end
    check("timeout_req_cycles", reqc, 15);
    #1;
    check("timeout_err", 32'({mem_err_o, mem_req_o}), 32'b10);
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = 1'b1;
      #1 check("err_sticky", 32'(all_outputs()), 32'h2);
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    rst_n = 1'b0;
    #1 check("err_cleared_by_reset", 32'(mem_err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ack in the 15th request cycle still wins, for fetch and for data
    run_instr(7'h13, 1'b0, 14, 0);
    run_instr(7'h03, 1'b0, 0, 14);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    // Illegal opcode enters the sticky TRAP state
    mem_ack_i = 1'b1;
    #1 opcode_i = 7'h7F;
    @(negedge clk);
    mem_ack_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = 1'(i & 1);
      #1 check("trap_sticky", 32'(all_outputs()), 32'h1);
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
